// File: rtl/alu_muldiv_decoder.sv
// ALU control decoder plus iterative HI/LO multiply/divide unit (mult, multu, div, divu).
// Decode is combinational; mul/div finish WIDTH cycles after launch, divide-by-zero after 1 cycle.
// While busy, further muldiv/mfhi/mflo instructions are held off through stall; ALU ops flow freely.
module alu_muldiv_decoder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       func,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [2:0]       ALUControl,
    output logic [1:0]       hilo_sel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // iteration state: acc holds {partial product | remainder, multiplier | quotient}
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;       // multiplicand magnitude or divisor magnitude
    logic                 neg_res;   // product / quotient must be negated at the end
    logic                 neg_rem;   // remainder takes the dividend's sign
    logic                 dz_pend;   // divide by zero captured at launch

    logic is_rtype, is_muldiv, is_mfhi, is_mflo;
    logic launch, last;
    logic op_div, op_sgn, a_neg, b_neg, src_b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, mul_fix;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     q_fix, r_fix;

    assign is_rtype  = (ALUOp == 3'b010);
    assign is_muldiv = is_rtype && (func[5:2] == 4'b0110);
    assign is_mfhi   = is_rtype && (func == F_MFHI);
    assign is_mflo   = is_rtype && (func == F_MFLO);

    // ALU select decode; anything unlisted falls back to AND so the ALU never sees X
    always_comb begin
        ALUControl = 3'b000;
        case (ALUOp)
            3'b000: ALUControl = 3'b010;
            3'b001: ALUControl = 3'b110;
            3'b011: ALUControl = 3'b101;
            3'b100: ALUControl = 3'b110;
            3'b010: begin
                case (func)
                    F_ADD:   ALUControl = 3'b010;
                    F_SUB:   ALUControl = 3'b110;
                    F_AND:   ALUControl = 3'b000;
                    F_OR:    ALUControl = 3'b001;
                    F_SLT:   ALUControl = 3'b111;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // writeback mux select for mfhi/mflo
    always_comb begin
        hilo_sel = 2'b00;
        if (is_mfhi) begin
            hilo_sel = 2'b01;
        end else if (is_mflo) begin
            hilo_sel = 2'b10;
        end
    end

    assign busy   = (state != IDLE);
    assign stall  = busy && start && (is_muldiv || is_mfhi || is_mflo);
    assign launch = (state == IDLE) && start && is_muldiv;
    assign last   = (cnt == CW'(WIDTH - 1));

    // func[1] selects divide, func[0] selects unsigned
    assign op_div     = func[1];
    assign op_sgn     = ~func[0];
    assign a_neg      = op_sgn && src_a[WIDTH-1];
    assign b_neg      = op_sgn && src_b[WIDTH-1];
    assign a_mag      = a_neg ? -src_a : src_a;
    assign b_mag      = b_neg ? -src_b : src_b;
    assign src_b_zero = (src_b == '0);

    // one shift-add step and one restoring-divide step, plus end-of-run sign correction
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        mul_fix   = neg_res ? -mul_next : mul_next;

        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        div_diff  = div_shift[WIDTH-1:0] - opb;
        div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        q_fix     = neg_res ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        r_fix     = neg_rem ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: launch from IDLE, return after the last iteration (or at once on divide by zero)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = op_div ? DIV : MUL;
                end
            end
            MUL: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            DIV: begin
                if (dz_pend || last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: capture at launch, iterate, write HI/LO and pulse done at completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dz_pend     <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        cnt     <= '0;
                        neg_res <= a_neg ^ b_neg;
                        if (op_div) begin
                            opb     <= b_mag;
                            neg_rem <= a_neg;
                            dz_pend <= src_b_zero;
                            // on divide by zero the raw dividend is parked here for HI
                            acc     <= {{WIDTH{1'b0}}, (src_b_zero ? src_a : a_mag)};
                        end else begin
                            opb     <= a_mag;
                            neg_rem <= 1'b0;
                            dz_pend <= 1'b0;
                            acc     <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        cnt      <= '0;
                        {hi, lo} <= mul_fix;
                        done     <= 1'b1;
                    end
                end
                DIV: begin
                    if (dz_pend) begin
                        dz_pend     <= 1'b0;
                        lo          <= '1;
                        hi          <= acc[WIDTH-1:0];
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end else begin
                        acc <= div_next;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            cnt  <= '0;
                            lo   <= q_fix;
                            hi   <= r_fix;
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_decoder.sv
// Bench for alu_muldiv_decoder: arithmetic reference model checked every cycle plus literal expectations.
// Reference model is cycle-counted (launch, WIDTH or 1 cycles later completion) using native arithmetic.
// Stall expectations come from model busy and the current instruction class.
module tb_alu_muldiv_decoder;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    ALUOp = 3'b000;
    logic [5:0]    func = 6'b000000;
    logic          start = 1'b0;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic [2:0]    ALUControl;
    logic [1:0]    hilo_sel;
    logic [W-1:0]  hi, lo;
    logic          busy, done, div_by_zero, stall;

    alu_muldiv_decoder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .func(func), .start(start),
        .src_a(src_a), .src_b(src_b), .ALUControl(ALUControl), .hilo_sel(hilo_sel),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit run    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] exp_ctrl(input logic [2:0] op, input logic [5:0] f);
        if (op == 3'b000) return 3'b010;
        if (op == 3'b001 || op == 3'b100) return 3'b110;
        if (op == 3'b011) return 3'b101;
        if (op == 3'b010) begin
            if (f == 6'b100000) return 3'b010;
            if (f == 6'b100010) return 3'b110;
            if (f == 6'b100101) return 3'b001;
            if (f == 6'b101010) return 3'b111;
        end
        return 3'b000;
    endfunction

    function automatic bit is_md(input logic [2:0] op, input logic [5:0] f);
        return op == 3'b010 && (f == 6'b011000 || f == 6'b011001 || f == 6'b011010 || f == 6'b011011);
    endfunction

    function automatic logic [1:0] exp_hsel(input logic [2:0] op, input logic [5:0] f);
        if (op == 3'b010 && f == 6'b010000) return 2'b01;
        if (op == 3'b010 && f == 6'b010010) return 2'b10;
        return 2'b00;
    endfunction

    int           m_rem = 0;          // cycles left until completion, 0 when idle
    logic [W-1:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    bit           m_done = 1'b0, m_dz = 1'b0, m_pdz = 1'b0;
    logic [63:0]  m_p, m_q, m_r;
    longint       m_sa, m_sb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0; m_pdz = 1'b0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = m_phi; m_lo = m_plo; m_done = 1'b1; m_dz = m_pdz;
                end
            end else if (start && is_md(ALUOp, func)) begin
                m_pdz = 1'b0;
                m_rem = W;
                m_sa  = longint'($signed(src_a));
                m_sb  = longint'($signed(src_b));
                case (func)
                    6'b011000: m_p = m_sa * m_sb;
                    6'b011001: m_p = {32'h0, src_a} * {32'h0, src_b};
                    default:   m_p = '0;
                endcase
                if (func[1] == 1'b0) begin
                    m_phi = m_p[63:32];
                    m_plo = m_p[31:0];
                end else if (src_b == '0) begin
                    m_phi = src_a; m_plo = '1; m_pdz = 1'b1; m_rem = 1;
                end else begin
                    if (func[0] == 1'b0) begin
                        m_q = m_sa / m_sb;
                        m_r = m_sa % m_sb;
                    end else begin
                        m_q = {32'h0, src_a} / {32'h0, src_b};
                        m_r = {32'h0, src_a} % {32'h0, src_b};
                    end
                    m_plo = m_q[31:0];
                    m_phi = m_r[31:0];
                end
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (run) begin
            chk("m_ALUControl", 64'(ALUControl), 64'(exp_ctrl(ALUOp, func)));
            chk("m_hilo_sel",   64'(hilo_sel),   64'(exp_hsel(ALUOp, func)));
            chk("m_busy",       64'(busy),       64'(m_rem > 0));
            chk("m_done",       64'(done),       64'(m_done));
            chk("m_div_by_zero",64'(div_by_zero),64'(m_dz));
            chk("m_hi",         64'(hi),         64'(m_hi));
            chk("m_lo",         64'(lo),         64'(m_lo));
            chk("m_stall",      64'(stall),
                64'((m_rem > 0) && start && (is_md(ALUOp, func) || exp_hsel(ALUOp, func) != 2'b00)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2;
        ALUOp = op; func = f; start = s; src_a = a; src_b = b;
    endtask

    // called just after a launch edge; returns edges from launch to completion
    task automatic wait_done(output bit seen, output int lat);
        seen = 1'b0;
        lat  = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = i - 1;
                break;
            end
        end
    endtask

    task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int lat_x, input logic [31:0] hi_x,
                          input logic [31:0] lo_x, input logic dz_x);
        bit seen;
        int lat;
        drive(3'b010, f, 1'b1, a, b);
        @(posedge clk);
        #2;
        // operands and func change after launch must not disturb the result
        start = 1'b0; src_a = ~a; src_b = a ^ 32'h5A5A_0F0F; func = 6'b100000;
        wait_done(seen, lat);
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({nm, "_latency"}, 64'(lat), 64'(lat_x));
            chk({nm, "_hi"}, 64'(hi), 64'(hi_x));
            chk({nm, "_lo"}, 64'(lo), 64'(lo_x));
            chk({nm, "_dz"}, 64'(div_by_zero), 64'(dz_x));
            @(negedge clk);
            chk({nm, "_done_width"}, 64'(done), 64'd0);
            chk({nm, "_hi_hold"}, 64'(hi), 64'(hi_x));
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [5:0] f;
        logic [2:0] ctrl;
        logic [1:0] hs;
    } vec_t;

    vec_t tbl[17] = '{
        '{3'b000, 6'b000000, 3'b010, 2'b00},
        '{3'b001, 6'b100000, 3'b110, 2'b00},
        '{3'b011, 6'b000000, 3'b101, 2'b00},
        '{3'b100, 6'b101010, 3'b110, 2'b00},
        '{3'b101, 6'b100000, 3'b000, 2'b00},
        '{3'b110, 6'b100000, 3'b000, 2'b00},
        '{3'b111, 6'b100101, 3'b000, 2'b00},
        '{3'b010, 6'b100000, 3'b010, 2'b00},
        '{3'b010, 6'b100010, 3'b110, 2'b00},
        '{3'b010, 6'b100100, 3'b000, 2'b00},
        '{3'b010, 6'b100101, 3'b001, 2'b00},
        '{3'b010, 6'b101010, 3'b111, 2'b00},
        '{3'b010, 6'b111111, 3'b000, 2'b00},
        '{3'b010, 6'b010000, 3'b000, 2'b01},
        '{3'b010, 6'b010010, 3'b000, 2'b10},
        '{3'b000, 6'b010010, 3'b010, 2'b00},
        '{3'b010, 6'b011000, 3'b000, 2'b00}
    };

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int lat;
        int cnt;

        repeat (2) @(posedge clk);
        run = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi",   64'(hi),   64'd0);
        chk("reset_lo",   64'(lo),   64'd0);
        chk("reset_done", 64'(done), 64'd0);
        drive(3'b000, 6'b000000, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // decoder table
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].f, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            chk("tbl_ctrl", 64'(ALUControl), 64'(tbl[i].ctrl));
            chk("tbl_hsel", 64'(hilo_sel), 64'(tbl[i].hs));
        end

        // add with start: no launch, no stall
        drive(3'b010, 6'b100000, 1'b1, 32'd1, 32'd2);
        @(negedge clk);
        chk("add_ctrl",  64'(ALUControl), 64'(3'b010));
        chk("add_hsel",  64'(hilo_sel), 64'(2'b00));
        chk("add_busy",  64'(busy), 64'd0);
        chk("add_stall", 64'(stall), 64'd0);

        run_op("mult_m3x5",   6'b011000, 32'hFFFF_FFFD, 32'd5,        32, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("multu_max",   6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_minsq",  6'b011000, 32'h8000_0000, 32'h8000_0000, 32, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("divu_100_7",  6'b011011, 32'd100,       32'd7,        32, 32'd2,        32'd14,        1'b0);
        run_op("div_m7_2",    6'b011010, 32'hFFFF_FFF9, 32'd2,        32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2",    6'b011010, 32'd7,         32'hFFFF_FFFE, 32, 32'd1,        32'hFFFF_FFFD, 1'b0);
        run_op("div_min_m1",  6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'd0,        32'h8000_0000, 1'b0);
        run_op("divu_big",    6'b011011, 32'hFFFF_FFFF, 32'd16,       32, 32'hF,        32'h0FFF_FFFF, 1'b0);
        run_op("div_5_0",     6'b011010, 32'd5,         32'd0,        1,  32'd5,        32'hFFFF_FFFF, 1'b1);
        run_op("divu_9_0",    6'b011011, 32'd9,         32'd0,        1,  32'd9,        32'hFFFF_FFFF, 1'b1);

        // mflo held while a mult is in flight
        drive(3'b010, 6'b011000, 1'b1, 32'd1000, 32'd1000);
        @(posedge clk);
        #2;
        func = 6'b010010; src_a = 32'd3; src_b = 32'd3;
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy && stall) cnt++;
        end
        chk("mflo_stall_cycles", 64'(cnt), 64'd32);
        chk("mflo_done_seen", 64'(seen), 64'd1);
        chk("mflo_done_stall", 64'(stall), 64'd0);
        chk("mflo_done_hsel", 64'(hilo_sel), 64'(2'b10));
        chk("mflo_done_lo", 64'(lo), 64'h000F_4240);
        drive(3'b000, 6'b000000, 1'b0, 32'h0, 32'h0);

        // a muldiv stalled behind a divu launches right after the done cycle
        drive(3'b010, 6'b011011, 1'b1, 32'd100, 32'd7);
        @(posedge clk);
        #2;
        func = 6'b011000; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
        @(negedge clk);
        chk("queued_stall", 64'(stall), 64'd1);
        wait_done(seen, lat);
        chk("queued_first_lat", 64'(lat), 64'd31);
        chk("queued_first_lo", 64'(lo), 64'd14);
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(seen, lat);
        chk("queued_second_lat", 64'(lat), 64'd32);
        chk("queued_second_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("queued_second_lo", 64'(lo), 64'hFFFF_FFF1);

        // ALU op proceeds during a mult, then reset aborts it at cycle 10
        drive(3'b010, 6'b011001, 1'b1, 32'd12345, 32'd678);
        @(posedge clk);
        #2;
        func = 6'b100010;
        @(negedge clk);
        chk("alu_busy_busy",  64'(busy), 64'd1);
        chk("alu_busy_ctrl",  64'(ALUControl), 64'(3'b110));
        chk("alu_busy_stall", 64'(stall), 64'd0);
        repeat (9) @(posedge clk);
        #2;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("rst_no_done", 64'(cnt), 64'd0);

        // launch presented during reset goes at the first edge after release
        drive(3'b010, 6'b011001, 1'b1, 32'd6, 32'd7);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(seen, lat);
        chk("post_rst_lat", 64'(lat), 64'd32);
        chk("post_rst_lo",  64'(lo), 64'd42);
        chk("post_rst_hi",  64'(hi), 64'd0);

        repeat (2) @(posedge clk);
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
